decode_pipe: RTL and testbench

Pipelined successor to the single-cycle decode stage. It accepts one fetched instruction per cycle and reads operands from an internal register file with write-back bypass. It generates the immediate, detects load-use hazards, and registers everything into an ID/EX pipeline register with a valid/ready handshake. It sits between the fetch stage and the execute stage, and takes write-back from the final stage.

---
 rtl/decode_pipe.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage. Reads operands from an internal
// register file (with optional same-cycle write-back bypass), builds the
// sign-extended immediate, detects load-use hazards and registers the
// result into an ID/EX pipeline register under a valid/ready handshake.
module decode_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int BYPASS     = 1,
    parameter int STAT_WIDTH = 16,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [DATA_WIDTH-1:0] if_instr,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  id_ready,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_instr,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [AW-1:0]         ex_rd,
    output logic                  ex_rd_we,
    output logic                  ex_is_load,
    output logic                  ex_illegal,
    output logic [STAT_WIDTH-1:0] stall_count,
    output logic [STAT_WIDTH-1:0] flush_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // A 5-bit register field that does not fit the implemented register file.
    function automatic logic idx_out_of_range(input logic [4:0] idx);
        idx_out_of_range = (int'(idx) >= REG_COUNT);
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + STAT_WIDTH'(1'b1);
        end
    endfunction

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];

    logic [6:0]            opcode_s;
    logic [4:0]            rs1_idx_s;
    logic [4:0]            rs2_idx_s;
    logic [4:0]            rd_idx_s;
    logic [AW-1:0]         rs1_s;
    logic [AW-1:0]         rs2_s;
    logic [AW-1:0]         rd_s;
    logic                  uses_rs1_s;
    logic                  uses_rs2_s;
    logic                  writes_rd_s;
    logic                  known_op_s;
    logic [31:0]           imm32_s;
    logic [DATA_WIDTH-1:0] imm_s;
    logic                  is_load_s;
    logic                  rd_we_s;
    logic                  illegal_s;
    logic [DATA_WIDTH-1:0] rs1_data_s;
    logic [DATA_WIDTH-1:0] rs2_data_s;
    logic                  hazard_s;
    logic                  id_ready_s;
    logic                  load_s;
    logic                  stall_s;

    logic                  ex_valid_r;
    logic [DATA_WIDTH-1:0] ex_instr_r;
    logic [DATA_WIDTH-1:0] ex_pc_r;
    logic [DATA_WIDTH-1:0] ex_rs1_data_r;
    logic [DATA_WIDTH-1:0] ex_rs2_data_r;
    logic [DATA_WIDTH-1:0] ex_imm_r;
    logic [AW-1:0]         ex_rd_r;
    logic                  ex_rd_we_r;
    logic                  ex_is_load_r;
    logic                  ex_illegal_r;
    logic [STAT_WIDTH-1:0] stall_count_r;
    logic [STAT_WIDTH-1:0] flush_count_r;

    // Field extraction and per-format immediate / operand-usage decode.
    always_comb begin
        opcode_s    = if_instr[6:0];
        rs1_idx_s   = if_instr[19:15];
        rs2_idx_s   = if_instr[24:20];
        rd_idx_s    = if_instr[11:7];
        rs1_s       = rs1_idx_s[AW-1:0];
        rs2_s       = rs2_idx_s[AW-1:0];
        rd_s        = rd_idx_s[AW-1:0];
        uses_rs1_s  = 1'b1;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        known_op_s  = 1'b1;
        imm32_s     = 32'h0000_0000;
        case (opcode_s)
            OP_R: begin
                uses_rs2_s  = 1'b1;
                writes_rd_s = 1'b1;
            end
            OP_IALU, OP_LOAD, OP_JALR: begin
                writes_rd_s = 1'b1;
                imm32_s     = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                uses_rs2_s = 1'b1;
                imm32_s    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OP_BRANCH: begin
                uses_rs2_s = 1'b1;
                imm32_s    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                              if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                uses_rs1_s  = 1'b0;
                writes_rd_s = 1'b1;
                imm32_s     = {if_instr[31:12], 12'h000};
            end
            OP_JAL: begin
                uses_rs1_s  = 1'b0;
                writes_rd_s = 1'b1;
                imm32_s     = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                               if_instr[20], if_instr[30:21], 1'b0};
            end
            default: begin
                known_op_s = 1'b0;
            end
        endcase
    end

    // Derived decode flags; only register fields the opcode actually uses
    // can make it illegal (immediate bits overlapping rs2 are not indices).
    always_comb begin
        imm_s     = DATA_WIDTH'($signed(imm32_s));
        is_load_s = (opcode_s == OP_LOAD);
        rd_we_s   = writes_rd_s && (rd_s != {AW{1'b0}});
        illegal_s = !known_op_s
                  || (uses_rs1_s  && idx_out_of_range(rs1_idx_s))
                  || (uses_rs2_s  && idx_out_of_range(rs2_idx_s))
                  || (writes_rd_s && idx_out_of_range(rd_idx_s));
    end

    // Register file write port; x0 is never written so it always reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wb_en && (wb_addr != {AW{1'b0}})) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Read port 1 with optional same-cycle write-back forwarding.
    always_comb begin
        if (rs1_s == {AW{1'b0}}) begin
            rs1_data_s = {DATA_WIDTH{1'b0}};
        end else if ((BYPASS != 0) && wb_en && (wb_addr == rs1_s)) begin
            rs1_data_s = wb_data;
        end else begin
            rs1_data_s = regs_r[rs1_s];
        end
    end

    // Read port 2 with optional same-cycle write-back forwarding.
    always_comb begin
        if (rs2_s == {AW{1'b0}}) begin
            rs2_data_s = {DATA_WIDTH{1'b0}};
        end else if ((BYPASS != 0) && wb_en && (wb_addr == rs2_s)) begin
            rs2_data_s = wb_data;
        end else begin
            rs2_data_s = regs_r[rs2_s];
        end
    end

    // Load-use hazard: the load in ID/EX targets a register this instruction reads.
    always_comb begin
        hazard_s = ex_valid_r && ex_is_load_r && (ex_rd_r != {AW{1'b0}})
                && ((uses_rs1_s && (rs1_s == ex_rd_r)) || (uses_rs2_s && (rs2_s == ex_rd_r)));
    end

    // Handshake priority: flush, then execute back-pressure, then stall, then issue.
    always_comb begin
        id_ready_s = 1'b1;
        load_s     = 1'b0;
        stall_s    = 1'b0;
        if (flush) begin
            id_ready_s = 1'b1;
        end else if (!ex_ready) begin
            id_ready_s = 1'b0;
        end else if (if_valid && hazard_s) begin
            id_ready_s = 1'b0;
            stall_s    = 1'b1;
        end else begin
            load_s = 1'b1;
        end
    end

    // ID/EX pipeline register; bubbles and flushes only clear the valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_r    <= 1'b0;
            ex_instr_r    <= {DATA_WIDTH{1'b0}};
            ex_pc_r       <= {DATA_WIDTH{1'b0}};
            ex_rs1_data_r <= {DATA_WIDTH{1'b0}};
            ex_rs2_data_r <= {DATA_WIDTH{1'b0}};
            ex_imm_r      <= {DATA_WIDTH{1'b0}};
            ex_rd_r       <= {AW{1'b0}};
            ex_rd_we_r    <= 1'b0;
            ex_is_load_r  <= 1'b0;
            ex_illegal_r  <= 1'b0;
        end else if (flush || stall_s) begin
            ex_valid_r <= 1'b0;
        end else if (load_s) begin
            ex_valid_r    <= if_valid;
            ex_instr_r    <= if_instr;
            ex_pc_r       <= if_pc;
            ex_rs1_data_r <= rs1_data_s;
            ex_rs2_data_r <= rs2_data_s;
            ex_imm_r      <= imm_s;
            ex_rd_r       <= rd_s;
            ex_rd_we_r    <= rd_we_s;
            ex_is_load_r  <= is_load_s;
            ex_illegal_r  <= illegal_s;
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= {STAT_WIDTH{1'b0}};
            flush_count_r <= {STAT_WIDTH{1'b0}};
        end else begin
            if (stall_s) begin
                stall_count_r <= sat_inc(stall_count_r);
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (flush) begin
                flush_count_r <= sat_inc(flush_count_r);
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign id_ready    = id_ready_s;
    assign ex_valid    = ex_valid_r;
    assign ex_instr    = ex_instr_r;
    assign ex_pc       = ex_pc_r;
    assign ex_rs1_data = ex_rs1_data_r;
    assign ex_rs2_data = ex_rs2_data_r;
    assign ex_imm      = ex_imm_r;
    assign ex_rd       = ex_rd_r;
    assign ex_rd_we    = ex_rd_we_r;
    assign ex_is_load  = ex_is_load_r;
    assign ex_illegal  = ex_illegal_r;
    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe (RV32E register file, 2-bit counters): directed
// scenarios with literal expectations plus randomized traffic compared
// every cycle against a behavioural model.
module tb_decode_pipe;

    localparam int RC   = 16;
    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [3:0]  ex_rd;
    logic        ex_rd_we;
    logic        ex_is_load;
    logic        ex_illegal;
    logic [1:0]  stall_count;
    logic [1:0]  flush_count;

    decode_pipe #(
        .DATA_WIDTH(32), .REG_COUNT(RC), .BYPASS(1), .STAT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid), .ex_instr(ex_instr),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_illegal(ex_illegal), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit go       = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] imm;
        logic        u1;
        logic        u2;
        logic        we;
        logic        ill;
        logic        ld;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
    } dec_t;

    function automatic dec_t dec(input logic [31:0] i);
        dec_t d;
        int   v;
        logic wr;
        logic known;
        d = '0; v = 0; wr = 1'b0; known = 1'b1;
        d.u1 = 1'b1;
        case (i[6:0])
            7'h33:               begin d.u2 = 1'b1; wr = 1'b1; v = 0; end
            7'h13, 7'h03, 7'h67: begin wr = 1'b1; v = $signed(i[31:20]); end
            7'h23:               begin d.u2 = 1'b1; v = $signed({i[31:25], i[11:7]}); end
            7'h63:               begin d.u2 = 1'b1; v = $signed({i[31], i[7], i[30:25], i[11:8]}); v = v * 2; end
            7'h37, 7'h17:        begin d.u1 = 1'b0; wr = 1'b1; v = int'({i[31:12], 12'h000}); end
            7'h6F:               begin d.u1 = 1'b0; wr = 1'b1; v = $signed({i[31], i[19:12], i[20], i[30:21]}); v = v * 2; end
            default:             known = 1'b0;
        endcase
        d.imm = v;
        d.rs1 = 4'(i[19:15]);
        d.rs2 = 4'(i[24:20]);
        d.rd  = 4'(i[11:7]);
        d.we  = wr && (d.rd != 4'd0);
        d.ld  = (i[6:0] == 7'h03);
        d.ill = !known || (d.u1 && i[19:15] >= 5'd16) || (d.u2 && i[24:20] >= 5'd16)
              || (wr && i[11:7] >= 5'd16);
        return d;
    endfunction

    logic [31:0] m_regs [RC];
    logic        m_valid, m_we, m_ld, m_ill;
    logic [31:0] m_instr, m_pc, m_r1, m_r2, m_imm;
    logic [3:0]  m_rd;
    int          m_stall, m_flush;

    dec_t cur_d;
    logic cur_hz;
    logic exp_ready;
    assign cur_d     = dec(if_instr);
    assign cur_hz    = m_valid && m_ld && (m_rd != 4'd0)
                     && ((cur_d.u1 && cur_d.rs1 == m_rd) || (cur_d.u2 && cur_d.rs2 == m_rd));
    assign exp_ready = flush ? 1'b1 : (!ex_ready ? 1'b0 : !(if_valid && cur_hz));

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RC; k++) m_regs[k] <= 32'd0;
            m_valid <= 1'b0; m_stall <= 0; m_flush <= 0;
            m_instr <= 32'd0; m_pc <= 32'd0; m_r1 <= 32'd0; m_r2 <= 32'd0; m_imm <= 32'd0;
            m_rd <= 4'd0; m_we <= 1'b0; m_ld <= 1'b0; m_ill <= 1'b0;
        end else begin
            if (flush) begin
                m_valid <= 1'b0;
                if (m_flush < SMAX) m_flush <= m_flush + 1;
            end else if (!ex_ready) begin
                m_valid <= m_valid;
            end else if (if_valid && cur_hz) begin
                m_valid <= 1'b0;
                if (m_stall < SMAX) m_stall <= m_stall + 1;
            end else begin
                m_valid <= if_valid;
                m_instr <= if_instr;
                m_pc    <= if_pc;
                m_imm   <= cur_d.imm;
                m_rd    <= cur_d.rd;
                m_we    <= cur_d.we;
                m_ld    <= cur_d.ld;
                m_ill   <= cur_d.ill;
                m_r1    <= (cur_d.rs1 == 4'd0) ? 32'd0 :
                           (wb_en && wb_addr == cur_d.rs1) ? wb_data : m_regs[cur_d.rs1];
                m_r2    <= (cur_d.rs2 == 4'd0) ? 32'd0 :
                           (wb_en && wb_addr == cur_d.rs2) ? wb_data : m_regs[cur_d.rs2];
            end
            if (wb_en && wb_addr != 4'd0) m_regs[wb_addr] <= wb_data;
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (go) begin
            chk("ex_valid", ex_valid, m_valid);
            chk("id_ready", id_ready, exp_ready);
            chk("stall_count", stall_count, m_stall);
            chk("flush_count", flush_count, m_flush);
            if (m_valid) begin
                chk("ex_instr", ex_instr, m_instr);
                chk("ex_pc", ex_pc, m_pc);
                chk("ex_rs1_data", ex_rs1_data, m_r1);
                chk("ex_rs2_data", ex_rs2_data, m_r2);
                chk("ex_imm", ex_imm, m_imm);
                chk("ex_rd", ex_rd, m_rd);
                chk("ex_rd_we", ex_rd_we, m_we);
                chk("ex_is_load", ex_is_load, m_ld);
                chk("ex_illegal", ex_illegal, m_ill);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic fl, input logic er,
                          input logic we, input logic [3:0] wa, input logic [31:0] wd);
        if_valid = v; if_instr = ins; if_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
        flush = fl; ex_ready = er; wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 10))
            0:       i[6:0] = 7'h33;
            1:       i[6:0] = 7'h13;
            2, 3:    i[6:0] = 7'h03;
            4:       i[6:0] = 7'h67;
            5:       i[6:0] = 7'h23;
            6:       i[6:0] = 7'h63;
            7:       i[6:0] = 7'h37;
            8:       i[6:0] = 7'h17;
            9:       i[6:0] = 7'h6F;
            default: i[6:0] = 7'($urandom);
        endcase
        if ($urandom_range(0, 7) != 0) begin
            i[11:7]  = 5'($urandom_range(0, 7));
            i[19:15] = 5'($urandom_range(0, 7));
            i[24:20] = 5'($urandom_range(0, 7));
        end
        return i;
    endfunction

    localparam logic [31:0] ADD_X6   = 32'h0002_8333; // add  x6,x5,x0
    localparam logic [31:0] ADDI_X8  = 32'hFFF3_8413; // addi x8,x7,-1
    localparam logic [31:0] LW_X3    = 32'h0000_A183; // lw   x3,0(x1)
    localparam logic [31:0] ADD_X4   = 32'h0021_8233; // add  x4,x3,x2
    localparam logic [31:0] ADD_X17  = 32'h0020_88B3; // add  x17,x1,x2
    localparam logic [31:0] ADDI_X0  = 32'h0050_0013; // addi x0,x0,5

    logic hold;

    initial begin
        rst = 1'b0;
        set_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
        step(); step();
        chk("lit_reset_ex_valid", ex_valid, 1'b0);
        chk("lit_reset_stall", stall_count, 2'd0);
        chk("lit_reset_flush", flush_count, 2'd0);
        chk("lit_reset_id_ready", id_ready, 1'b1);
        rst = 1'b1;
        go  = 1'b1;

        // write-back then dependent read
        set_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h0000_1234); step();
        set_in(1'b1, ADD_X6, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
        chk("lit_add_valid", ex_valid, 1'b1);
        chk("lit_add_rs1", ex_rs1_data, 32'h0000_1234);
        chk("lit_add_rd", ex_rd, 4'd6);
        chk("lit_add_rd_we", ex_rd_we, 1'b1);

        // same-cycle bypass
        set_in(1'b1, ADDI_X8, 1'b0, 1'b1, 1'b1, 4'd7, 32'h0000_DEAD); step();
        chk("lit_bypass_rs1", ex_rs1_data, 32'h0000_DEAD);
        chk("lit_bypass_imm", ex_imm, 32'hFFFF_FFFF);

        // load-use stall
        set_in(1'b1, LW_X3, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
        chk("lit_lw_is_load", ex_is_load, 1'b1);
        set_in(1'b1, ADD_X4, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); #1;
        chk("lit_stall_id_ready", id_ready, 1'b0);
        step();
        chk("lit_bubble_valid", ex_valid, 1'b0);
        chk("lit_stall_count1", stall_count, 2'd1);
        set_in(1'b1, ADD_X4, 1'b0, 1'b1, 1'b1, 4'd3, 32'h0000_0055); #1;
        chk("lit_after_stall_ready", id_ready, 1'b1);
        step();
        chk("lit_issue_valid", ex_valid, 1'b1);
        chk("lit_issue_instr", ex_instr, ADD_X4);
        chk("lit_issue_rs1", ex_rs1_data, 32'h0000_0055);

        // flush beats back-pressure
        set_in(1'b1, ADDI_X0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0); #1;
        chk("lit_flush_ready", id_ready, 1'b1);
        step();
        chk("lit_flush_valid", ex_valid, 1'b0);
        chk("lit_flush_count", flush_count, 2'd1);

        // register index out of range, and write to x0
        set_in(1'b1, ADD_X17, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
        chk("lit_illegal", ex_illegal, 1'b1);
        set_in(1'b1, ADDI_X0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
        chk("lit_x0_rd_we", ex_rd_we, 1'b0);
        chk("lit_x0_legal", ex_illegal, 1'b0);
        chk("lit_x0_imm", ex_imm, 32'd5);

        // three more stalls saturate the 2-bit counter
        for (int n = 0; n < 3; n++) begin
            set_in(1'b1, LW_X3, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
            set_in(1'b1, ADD_X4, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
            step();
        end
        chk("lit_stall_saturated", stall_count, 2'd3);

        // reset asserted while a stall is pending
        set_in(1'b1, LW_X3, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
        set_in(1'b1, ADD_X4, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); #1;
        rst = 1'b0; #1;
        chk("lit_async_valid", ex_valid, 1'b0);
        chk("lit_async_stall", stall_count, 2'd0);
        chk("lit_async_flush", flush_count, 2'd0);
        step();
        chk("lit_rst_edge_valid", ex_valid, 1'b0);
        chk("lit_rst_edge_stall", stall_count, 2'd0);
        rst = 1'b1;
        set_in(1'b1, ADD_X6, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0); step();
        chk("lit_regfile_cleared", ex_rs1_data, 32'd0);
        chk("lit_post_rst_valid", ex_valid, 1'b1);

        // randomized traffic; fetch holds its outputs while id_ready is low
        hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                if_valid = ($urandom_range(0, 9) != 0);
                if_instr = gen_instr();
                if_pc    = $urandom;
            end
            flush    = ($urandom_range(0, 19) == 0);
            ex_ready = ($urandom_range(0, 5) != 0);
            wb_en    = ($urandom_range(0, 1) != 0);
            wb_addr  = 4'($urandom_range(0, 15));
            wb_data  = $urandom;
            #1;
            hold = if_valid && !exp_ready;
            if ((n % 800) == 400) begin
                #1 rst = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b1;
                hold = 1'b0;
            end
            step();
        end

        go = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
